// File: rtl/mem_port_ctrl_pkg.sv
// Shared widths, state/owner encodings and byte-lane helpers for the memory port controller.
package mem_port_ctrl_pkg;

   localparam int MEM_ADDR_BUS   = 32;
   localparam int REG_BUS        = 32;
   localparam int BYTE_BUS       = 8;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_MEM  = 2'd2
   } owner_t;

   // Little-endian byte lane extract: lane 0 is bits [7:0].
   function automatic logic [BYTE_BUS-1:0] word_byte(logic [REG_BUS-1:0] w, logic [1:0] idx);
      logic [BYTE_BUS-1:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   // Little-endian byte lane replace.
   function automatic logic [REG_BUS-1:0] word_put(logic [REG_BUS-1:0] w, logic [1:0] idx,
                                                   logic [BYTE_BUS-1:0] b);
      logic [REG_BUS-1:0] r;
      r = w;
      case (idx)
         2'd0:    r[7:0]   = b;
         2'd1:    r[15:8]  = b;
         2'd2:    r[23:16] = b;
         default: r[31:24] = b;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_port_ctrl_byte_sequencer.sv
// Byte engine: walks a latched word access through four byte transactions on the
// external bus, skips masked-off store bytes, and assembles read bytes into a word.
module mem_port_ctrl_byte_sequencer
   import mem_port_ctrl_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [ADDR_W-1:0]   load_addr,
   input  logic                load_we,
   input  logic [REG_BUS-1:0]  load_wdata,
   input  logic [3:0]          load_mask,
   input  logic                access,
   input  logic                ext_ack,
   input  logic [BYTE_BUS-1:0] ext_rdata,
   output logic                step,
   output logic                last,
   output logic [REG_BUS-1:0]  word_next,
   output logic                ext_req,
   output logic                ext_we,
   output logic [ADDR_W-1:0]   ext_addr,
   output logic [BYTE_BUS-1:0] ext_wdata
);

   logic [ADDR_W-1:0]  base_q;
   logic               we_q;
   logic [REG_BUS-1:0] wdata_q;
   logic [3:0]         mask_q;
   logic [1:0]         cnt_q;
   logic [REG_BUS-1:0] asm_q;
   logic               byte_en;
   logic               rd_ack;

   // A store byte with its enable clear is a silent one-cycle slot.
   assign byte_en   = !we_q || mask_q[cnt_q];
   assign ext_req   = access && byte_en;
   assign ext_we    = access && we_q;
   assign ext_addr  = access ? base_q + {{(ADDR_W-2){1'b0}}, cnt_q} : '0;
   assign ext_wdata = access ? word_byte(wdata_q, cnt_q) : '0;
   assign rd_ack    = ext_req && ext_ack && !we_q;
   assign step      = access && (!byte_en || ext_ack);
   assign last      = step && (cnt_q == 2'(BYTES_PER_WORD - 1));

   // Word including the byte arriving this cycle, so the owner register can be
   // loaded on the same edge that finishes byte 3.
   assign word_next = rd_ack ? word_put(asm_q, cnt_q, ext_rdata) : asm_q;

   // Latch the granted access, then advance one byte per completed or skipped slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         mask_q  <= '0;
         cnt_q   <= '0;
         asm_q   <= '0;
      end else if (load) begin
         base_q  <= load_addr;
         we_q    <= load_we;
         wdata_q <= load_wdata;
         mask_q  <= load_mask;
         cnt_q   <= '0;
         asm_q   <= '0;
      end else if (step) begin
         cnt_q <= cnt_q + 2'd1;
         asm_q <= word_next;
      end
   end

endmodule

// File: rtl/mem_port_ctrl.sv
// Arbiter for the shared external byte port: MEM stage beats IF stage, each word
// is run as four byte transactions, and the owner gets a one-cycle done pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | port free; requests sampled, MEM wins, flushed IF ignored
// ST_ACCESS | byte sequencer running bytes 0..3 for the current owner
// ST_DONE   | one cycle; owner's done high, data register already updated
module mem_port_ctrl
   import mem_port_ctrl_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_BUS,
   parameter int DATA_W = REG_BUS
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_re,
   input  logic [ADDR_W-1:0]   if_addr,
   input  logic                if_flush,
   output logic                if_busy,
   output logic                if_done,
   output logic [DATA_W-1:0]   if_data,
   input  logic                mem_re,
   input  logic                mem_we,
   input  logic [ADDR_W-1:0]   mem_addr,
   input  logic [DATA_W-1:0]   mem_wdata,
   input  logic [3:0]          mem_mask,
   output logic                mem_busy,
   output logic                mem_done,
   output logic [DATA_W-1:0]   mem_rdata,
   output logic                ext_req,
   output logic                ext_we,
   output logic [ADDR_W-1:0]   ext_addr,
   output logic [BYTE_BUS-1:0] ext_wdata,
   input  logic                ext_ack,
   input  logic [BYTE_BUS-1:0] ext_rdata
);

   state_t             state_q, state_d;
   owner_t             owner_q, owner_d;
   logic               flush_q, flush_d;
   logic               grant;
   logic               finish;
   logic [ADDR_W-1:0]  g_addr;
   logic               g_we;
   logic [REG_BUS-1:0] g_wdata;
   logic [3:0]         g_mask;
   logic               step;
   logic               last;
   logic [REG_BUS-1:0] word_next;
   logic               mem_req;
   logic               if_ok;
   logic               if_abort;

   assign mem_req  = mem_re || mem_we;
   assign if_ok    = if_re && !if_flush;
   // A flush seen at any point of an IF access takes effect once the byte in flight completes.
   assign if_abort = (owner_q == OWN_IF) && (flush_q || if_flush);

   // State, owner and pending-flush registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         owner_q <= OWN_NONE;
         flush_q <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         flush_q <= flush_d;
      end
   end

   // Arbitration and sequencing; mem_we wins over mem_re so a combined request is a store.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      flush_d = flush_q;
      grant   = 1'b0;
      finish  = 1'b0;
      g_addr  = mem_addr;
      g_we    = mem_we;
      g_wdata = REG_BUS'(mem_wdata);
      g_mask  = mem_mask;
      case (state_q)
         ST_IDLE: begin
            flush_d = 1'b0;
            owner_d = OWN_NONE;
            if (mem_req) begin
               grant   = 1'b1;
               owner_d = OWN_MEM;
               state_d = ST_ACCESS;
            end else if (if_ok) begin
               grant   = 1'b1;
               owner_d = OWN_IF;
               state_d = ST_ACCESS;
               g_addr  = if_addr;
               g_we    = 1'b0;
               g_wdata = '0;
               g_mask  = 4'hF;
            end
         end
         ST_ACCESS: begin
            if (owner_q == OWN_IF && if_flush) begin
               flush_d = 1'b1;
            end
            if (step) begin
               if (if_abort) begin
                  state_d = ST_IDLE;
                  owner_d = OWN_NONE;
               end else if (last) begin
                  state_d = ST_DONE;
                  finish  = 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
         default: begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
         end
      endcase
   end

   mem_port_ctrl_byte_sequencer #(
      .ADDR_W (ADDR_W)
   ) u_seq (
      .clk        (clk),
      .rst        (rst),
      .load       (grant),
      .load_addr  (g_addr),
      .load_we    (g_we),
      .load_wdata (g_wdata),
      .load_mask  (g_mask),
      .access     (state_q == ST_ACCESS),
      .ext_ack    (ext_ack),
      .ext_rdata  (ext_rdata),
      .step       (step),
      .last       (last),
      .word_next  (word_next),
      .ext_req    (ext_req),
      .ext_we     (ext_we),
      .ext_addr   (ext_addr),
      .ext_wdata  (ext_wdata)
   );

   // Owner data registers load on the edge entering ST_DONE; stores leave mem_rdata alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_data   <= '0;
         mem_rdata <= '0;
      end else if (finish) begin
         if (owner_q == OWN_IF) begin
            if_data <= DATA_W'(word_next);
         end else if (!ext_we) begin
            mem_rdata <= DATA_W'(word_next);
         end
      end
   end

   assign if_done  = (state_q == ST_DONE) && (owner_q == OWN_IF);
   assign mem_done = (state_q == ST_DONE) && (owner_q == OWN_MEM);
   assign if_busy  = if_re && ((state_q != ST_IDLE) || mem_req) && !if_done;
   assign mem_busy = mem_req && (state_q != ST_IDLE) && !mem_done;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl: stimulus pushes expected byte transactions and
// done events into queues, a negedge monitor pops and compares them.
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_re, if_flush, if_busy, if_done;
   logic [31:0] if_addr, if_data;
   logic        mem_re, mem_we, mem_busy, mem_done;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_mask;
   logic        ext_req, ext_we, ext_ack;
   logic [31:0] ext_addr;
   logic [7:0]  ext_wdata, ext_rdata;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  wdata;
      int          cyc;
   } ext_t;

   typedef struct {
      bit          is_mem;
      logic [31:0] data;
      int          cyc;
   } done_t;

   ext_t  ext_q[$];
   done_t done_q[$];
   int    n_vec = 0;
   int    n_err = 0;
   int    cyc = 0;
   int    ack_delay = 0;
   int    wait_cnt = 0;
   bit    mon_en = 1'b0;
   int    t0;

   mem_port_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .if_re     (if_re),
      .if_addr   (if_addr),
      .if_flush  (if_flush),
      .if_busy   (if_busy),
      .if_done   (if_done),
      .if_data   (if_data),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_mask  (mem_mask),
      .mem_busy  (mem_busy),
      .mem_done  (mem_done),
      .mem_rdata (mem_rdata),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_ack   (ext_ack),
      .ext_rdata (ext_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Slave memory: fixed bytes at 0x100 (an addi instruction), a hash elsewhere.
   function automatic logic [7:0] rd_byte(logic [31:0] a);
      case (a)
         32'h100: return 8'h13;
         32'h101: return 8'h05;
         32'h102: return 8'h50;
         32'h103: return 8'h00;
         default: return a[7:0] ^ 8'hA5 ^ a[15:8];
      endcase
   endfunction

   always @(posedge clk) begin
      if (ext_req && !ext_ack) wait_cnt <= wait_cnt + 1;
      else                     wait_cnt <= 0;
   end

   assign ext_ack   = ext_req && (wait_cnt >= ack_delay);
   assign ext_rdata = rd_byte(ext_addr);

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_ext(logic [31:0] a, logic w, logic [7:0] d, int c);
      ext_t e;
      e.addr = a; e.we = w; e.wdata = d; e.cyc = c;
      ext_q.push_back(e);
   endtask

   task automatic push_read(logic [31:0] base, int first, int per);
      for (int k = 0; k < 4; k++) push_ext(base + 32'(k), 1'b0, 8'h00, first + k * per);
   endtask

   task automatic push_done(bit m, logic [31:0] d, int c);
      done_t x;
      x.is_mem = m; x.data = d; x.cyc = c;
      done_q.push_back(x);
   endtask

   task automatic wait_done(bit m, int max);
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (m ? mem_done : if_done) return;
      end
      n_vec++;
      n_err++;
      $display("FAIL wait_done timeout: got no done expected %s done", m ? "mem" : "if");
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: compares every presented byte transaction and done pulse to the queues.
   always @(negedge clk) begin
      if (mon_en) begin
         if (ext_req) begin
            if (ext_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL ext_unexpected: got addr 0x%0h expected no ext_req (cycle %0d)", ext_addr, cyc);
            end else begin
               check("ext_addr", ext_addr, ext_q[0].addr);
               check("ext_we", 32'(ext_we), 32'(ext_q[0].we));
               if (ext_q[0].we) check("ext_wdata", 32'(ext_wdata), 32'(ext_q[0].wdata));
               if (ext_ack) begin
                  check("ext_cycle", 32'(cyc), 32'(ext_q[0].cyc));
                  void'(ext_q.pop_front());
               end
            end
         end
         if (if_done || mem_done) begin
            if (done_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL done_unexpected: got if_done=%0b mem_done=%0b expected none (cycle %0d)",
                        if_done, mem_done, cyc);
            end else begin
               done_t d;
               d = done_q.pop_front();
               check("done_owner", 32'(mem_done), 32'(d.is_mem));
               check("done_exclusive", 32'(if_done & mem_done), 32'd0);
               check("done_data", d.is_mem ? mem_rdata : if_data, d.data);
               check("done_cycle", 32'(cyc), 32'(d.cyc));
               check("busy_at_done", 32'(d.is_mem ? mem_busy : if_busy), 32'd0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      if_re = 1'b0; if_addr = '0; if_flush = 1'b0;
      mem_re = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_mask = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      check("rst_ext_req", 32'(ext_req), 32'd0);
      check("rst_ext_we", 32'(ext_we), 32'd0);
      check("rst_ext_addr", ext_addr, 32'd0);
      check("rst_ext_wdata", 32'(ext_wdata), 32'd0);
      check("rst_if_done", 32'(if_done), 32'd0);
      check("rst_mem_done", 32'(mem_done), 32'd0);
      check("rst_if_data", if_data, 32'd0);
      check("rst_mem_rdata", mem_rdata, 32'd0);
      mon_en = 1'b1;
      next_cycle();

      // IF read at 0x100, ack tied high.
      t0 = cyc;
      if_addr = 32'h100; if_re = 1'b1;
      push_read(32'h100, t0 + 1, 1);
      push_done(1'b0, 32'h0050_0513, t0 + 5);
      wait_done(1'b0, 40);
      next_cycle();
      if_re = 1'b0;

      // Simultaneous IF and MEM reads: MEM first, IF granted once IDLE returns.
      t0 = cyc;
      if_addr = 32'h200; if_re = 1'b1;
      mem_addr = 32'h400; mem_re = 1'b1;
      push_read(32'h400, t0 + 1, 1);
      push_done(1'b1, 32'hA2A3_A0A1, t0 + 5);
      push_read(32'h200, t0 + 7, 1);
      push_done(1'b0, 32'hA4A5_A6A7, t0 + 11);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("if_busy_during_mem", 32'(if_busy), 32'd1);
      end
      next_cycle();
      mem_re = 1'b0;
      wait_done(1'b0, 40);
      next_cycle();
      if_re = 1'b0;

      // Masked store: only bytes 0 and 2 go on the bus; mem_rdata keeps the last load.
      t0 = cyc;
      mem_addr = 32'h10; mem_wdata = 32'hAABB_CCDD; mem_mask = 4'b0101; mem_we = 1'b1;
      push_ext(32'h10, 1'b1, 8'hDD, t0 + 1);
      push_ext(32'h12, 1'b1, 8'hBB, t0 + 3);
      push_done(1'b1, 32'hA2A3_A0A1, t0 + 5);
      wait_done(1'b1, 40);
      next_cycle();
      mem_we = 1'b0; mem_mask = 4'b0000;

      // Slave acks each byte after three wait cycles.
      ack_delay = 3;
      t0 = cyc;
      mem_addr = 32'h300; mem_re = 1'b1;
      push_read(32'h300, t0 + 4, 4);
      push_done(1'b1, 32'hA5A4_A7A6, t0 + 17);
      wait_done(1'b1, 80);
      next_cycle();
      mem_re = 1'b0;
      ack_delay = 0;

      // Fully masked store: four silent cycles, then done.
      t0 = cyc;
      mem_addr = 32'h20; mem_wdata = 32'h1122_3344; mem_mask = 4'b0000; mem_we = 1'b1;
      push_done(1'b1, 32'hA5A4_A7A6, t0 + 5);
      wait_done(1'b1, 40);
      next_cycle();
      mem_we = 1'b0;

      // Flush during byte 1 of an IF read; a MEM load issued next cycle proves IDLE.
      t0 = cyc;
      if_addr = 32'h200; if_re = 1'b1;
      push_ext(32'h200, 1'b0, 8'h00, t0 + 1);
      push_ext(32'h201, 1'b0, 8'h00, t0 + 2);
      next_cycle();
      next_cycle();
      if_flush = 1'b1;
      next_cycle();
      if_flush = 1'b0; if_re = 1'b0;
      mem_addr = 32'h400; mem_re = 1'b1;
      push_read(32'h400, t0 + 4, 1);
      push_done(1'b1, 32'hA2A3_A0A1, t0 + 8);
      @(negedge clk);
      check("flush_no_ext_req", 32'(ext_req), 32'd0);
      wait_done(1'b1, 40);
      next_cycle();
      mem_re = 1'b0;
      check("flush_if_data_kept", if_data, 32'hA4A5_A6A7);

      // Reset during byte 2 of a MEM load, then a fresh load.
      t0 = cyc;
      mem_addr = 32'h300; mem_re = 1'b1;
      push_ext(32'h300, 1'b0, 8'h00, t0 + 1);
      push_ext(32'h301, 1'b0, 8'h00, t0 + 2);
      push_ext(32'h302, 1'b0, 8'h00, t0 + 3);
      next_cycle();
      next_cycle();
      next_cycle();
      rst = 1'b1; mem_re = 1'b0;
      next_cycle();
      @(negedge clk);
      check("rst_mid_ext_req", 32'(ext_req), 32'd0);
      check("rst_mid_mem_done", 32'(mem_done), 32'd0);
      check("rst_mid_mem_rdata", mem_rdata, 32'd0);
      check("rst_mid_if_data", if_data, 32'd0);
      next_cycle();
      rst = 1'b0;
      t0 = cyc;
      mem_addr = 32'h300; mem_re = 1'b1;
      push_read(32'h300, t0 + 1, 1);
      push_done(1'b1, 32'hA5A4_A7A6, t0 + 5);
      wait_done(1'b1, 40);
      next_cycle();
      mem_re = 1'b0;

      repeat (4) @(negedge clk);
      check("ext_queue_drained", 32'(ext_q.size()), 32'd0);
      check("done_queue_drained", 32'(done_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
